game_flow_ctrl: RTL

- Top-level game sequencer. It sits directly downstream of the lives/health block and consumes its gameover flag.
- Drives the run/freeze enable for Bomberman, enemy and bomb logic.
- Generates a clean restart pulse that re-initialises the lives block and the other game blocks.
- Produces a title/game-over banner overlay for the pixel mux.

---
 rtl/game_flow_ctrl_pkg.sv | 35 +++
 rtl/game_flow_ctrl_btn_edge_sync.sv | 33 +++
 rtl/game_flow_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/game_flow_ctrl_pkg.sv
// Shared definitions for the game sequencer: state encoding, default timing,
// banner geometry and colours.
package game_flow_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_TITLE   = 3'd0,
        ST_RESTART = 3'd1,
        ST_PLAY    = 3'd2,
        ST_DYING   = 3'd3,
        ST_OVER    = 3'd4
    } state_e;

    localparam int FADE_FRAMES_DEF    = 90;
    localparam int BLINK_FRAMES_DEF   = 30;
    localparam int RESTART_CYCLES_DEF = 4;

    localparam int FRAME_CNT_W = 7;
    localparam int RST_CNT_W   = 3;

    localparam int BANNER_X0_DEF = 208;
    localparam int BANNER_X1_DEF = 416;
    localparam int BANNER_Y0_DEF = 208;
    localparam int BANNER_Y1_DEF = 272;

    localparam logic [11:0] RGB_TITLE = 12'h00F;
    localparam logic [11:0] RGB_OVER  = 12'hF00;

    // Half-open box test: left/top inclusive, right/bottom exclusive.
    function automatic logic in_box(input logic [9:0] px, input logic [9:0] py,
                                    input logic [9:0] x0, input logic [9:0] x1,
                                    input logic [9:0] y0, input logic [9:0] y1);
        return (px >= x0) && (px < x1) && (py >= y0) && (py < y1);
    endfunction

endpackage

// File: rtl/game_flow_ctrl_btn_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for a raw pushbutton.
// Produces a single-cycle pulse per press, however long the button is held.
module btn_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        pulse   = sync2_q & ~prev_q;
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: title / restart / play / dying / game-over flow,
// run-enable and restart pulse for the game blocks, and the banner overlay.
//
// state   | meaning
// TITLE   | idle after reset, solid blue banner, waiting for start
// RESTART | game_restart held high for RESTART_CYCLES clocks
// PLAY    | game running, game_en high
// DYING   | frozen for FADE_FRAMES frames before the banner
// OVER    | blinking red banner, waiting for start
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int FADE_FRAMES    = FADE_FRAMES_DEF,
    parameter int BLINK_FRAMES   = BLINK_FRAMES_DEF,
    parameter int RESTART_CYCLES = RESTART_CYCLES_DEF,
    parameter int BANNER_X0      = BANNER_X0_DEF,
    parameter int BANNER_X1      = BANNER_X1_DEF,
    parameter int BANNER_Y0      = BANNER_Y0_DEF,
    parameter int BANNER_Y1      = BANNER_Y1_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        frame_tick,
    input  logic        gameover,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic        game_en,
    output logic        game_restart,
    output logic        banner_on,
    output logic [11:0] banner_rgb,
    output logic [2:0]  state_dbg
);

    localparam logic [FRAME_CNT_W-1:0] FADE_CNT  = FRAME_CNT_W'(FADE_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] BLINK_CNT = FRAME_CNT_W'(BLINK_FRAMES);
    localparam logic [RST_CNT_W-1:0]   RST_LAST  = RST_CNT_W'(RESTART_CYCLES - 1);
    localparam logic [FRAME_CNT_W-1:0] FRAME_MAX = '1;
    localparam logic [RST_CNT_W-1:0]   RST_MAX   = '1;

    state_e                 state_q, state_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [RST_CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic                   blink_q, blink_d;
    logic                   game_en_q, game_en_d;
    logic                   game_restart_q, game_restart_d;

    logic                   start_pulse;
    logic [FRAME_CNT_W-1:0] frame_inc;
    logic [RST_CNT_W-1:0]   rst_inc;
    logic                   in_rect;

    btn_edge_sync u_start_sync (
        .clk    (clk),
        .rst_n  (reset),
        .btn_in (start_btn),
        .pulse  (start_pulse)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_TITLE;
            frame_cnt_q    <= '0;
            rst_cnt_q      <= '0;
            blink_q        <= 1'b0;
            game_en_q      <= 1'b0;
            game_restart_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            rst_cnt_q      <= rst_cnt_d;
            blink_q        <= blink_d;
            game_en_q      <= game_en_d;
            game_restart_q <= game_restart_d;
        end
    end

    // Counters saturate rather than wrap so a stuck count can never re-trigger.
    always_comb begin
        frame_inc   = (frame_cnt_q == FRAME_MAX) ? frame_cnt_q : frame_cnt_q + 1'b1;
        rst_inc     = (rst_cnt_q == RST_MAX) ? rst_cnt_q : rst_cnt_q + 1'b1;
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        rst_cnt_d   = rst_cnt_q;
        blink_d     = blink_q;
        unique case (state_q)
            ST_TITLE: begin
                if (start_pulse) begin
                    state_d   = ST_RESTART;
                    rst_cnt_d = '0;
                end
            end
            ST_RESTART: begin
                if (rst_cnt_q >= RST_LAST) begin
                    state_d   = ST_PLAY;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_inc;
                end
            end
            ST_PLAY: begin
                if (gameover) begin
                    state_d     = ST_DYING;
                    frame_cnt_d = '0;
                end
            end
            ST_DYING: begin
                if (frame_tick) begin
                    if (frame_inc >= FADE_CNT) begin
                        state_d     = ST_OVER;
                        frame_cnt_d = '0;
                        blink_d     = 1'b1;
                    end else begin
                        frame_cnt_d = frame_inc;
                    end
                end
            end
            ST_OVER: begin
                if (start_pulse) begin
                    state_d     = ST_RESTART;
                    frame_cnt_d = '0;
                    rst_cnt_d   = '0;
                    blink_d     = 1'b0;
                end else if (frame_tick) begin
                    if (frame_inc >= BLINK_CNT) begin
                        frame_cnt_d = '0;
                        blink_d     = ~blink_q;
                    end else begin
                        frame_cnt_d = frame_inc;
                    end
                end
            end
            default: begin
                state_d     = ST_TITLE;
                frame_cnt_d = '0;
                rst_cnt_d   = '0;
                blink_d     = 1'b0;
            end
        endcase
    end

    // Enables are registered from the next state; the banner is combinational
    // from registered state so it lines up with the other pixel sources.
    always_comb begin
        game_en_d      = (state_d == ST_PLAY);
        game_restart_d = (state_d == ST_RESTART);
        in_rect        = in_box(x, y, 10'(BANNER_X0), 10'(BANNER_X1),
                                10'(BANNER_Y0), 10'(BANNER_Y1));
        banner_on      = 1'b0;
        banner_rgb     = '0;
        if (in_rect && state_q == ST_TITLE) begin
            banner_on  = 1'b1;
            banner_rgb = RGB_TITLE;
        end else if (in_rect && state_q == ST_OVER && blink_q) begin
            banner_on  = 1'b1;
            banner_rgb = RGB_OVER;
        end
    end

    assign game_en      = game_en_q;
    assign game_restart = game_restart_q;
    assign state_dbg    = state_q;

endmodule
